// File: rtl/alu_issue_if.sv
// Bundle of the Hack ALU issue stage signals: instruction handshake, ALU operand/control and
// result bus, M write port, branch outputs and architectural register views.
interface alu_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] mem_in;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        busy;

    modport slave (
        input  instr_valid, instr, mem_in, alu_out, alu_zr, alu_ng,
        output instr_ready, alu_x, alu_y, zx, nx, zy, ny, f, no,
        output mem_we, mem_addr, mem_wdata, jump, jump_addr, a_reg, d_reg, busy
    );

    modport master (
        output instr_valid, instr, mem_in, alu_out, alu_zr, alu_ng,
        input  instr_ready, alu_x, alu_y, zx, nx, zy, ny, f, no,
        input  mem_we, mem_addr, mem_wdata, jump, jump_addr, a_reg, d_reg, busy
    );
endinterface

// File: rtl/alu_issue.sv
// Hack CPU issue stage: A-instructions load A in one cycle; C-instructions walk
// IDLE -> ISSUE -> WB, driving an external ALU and writing back A/D/M and branches.
module alu_issue (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    // Bits 15:13 of a C-instruction carry no meaning once decoded, so only 12:0 are kept.
    logic [12:0] ir_q, ir_d;
    logic [15:0] res_q, res_d;
    logic        zr_q, zr_d;
    logic        ng_q, ng_d;

    logic        instr_ready;
    logic        busy;
    logic [5:0]  ctrl;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        jump;
    logic [15:0] jump_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        res_d   = res_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    if (!bus.instr[15]) begin
                        a_d = {1'b0, bus.instr[14:0]};
                    end else begin
                        ir_d    = bus.instr[12:0];
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                res_d   = bus.alu_out;
                zr_d    = bus.alu_zr;
                ng_d    = bus.alu_ng;
                state_d = StWb;
            end
            StWb: begin
                // Write-back goes after the M write/branch, which use the pre-update A.
                if (ir_q[5]) a_d = res_q;
                if (ir_q[4]) d_d = res_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b1;
        ctrl        = '0;
        alu_x       = '0;
        alu_y       = '0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        jump        = 1'b0;
        jump_addr   = '0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
            end
            StIssue: begin
                ctrl  = ir_q[11:6];
                alu_x = d_q;
                alu_y = ir_q[12] ? bus.mem_in : a_q;
            end
            StWb: begin
                mem_we    = ir_q[3];
                mem_addr  = a_q;
                mem_wdata = res_q;
                jump      = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);
                jump_addr = a_q;
            end
            default: busy = 1'b1;
        endcase
    end

    assign bus.instr_ready = instr_ready;
    assign bus.busy        = busy;
    assign bus.zx          = ctrl[5];
    assign bus.nx          = ctrl[4];
    assign bus.zy          = ctrl[3];
    assign bus.ny          = ctrl[2];
    assign bus.f           = ctrl[1];
    assign bus.no          = ctrl[0];
    assign bus.alu_x       = alu_x;
    assign bus.alu_y       = alu_y;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.jump        = jump;
    assign bus.jump_addr   = jump_addr;
    assign bus.a_reg       = a_q;
    assign bus.d_reg       = d_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural Hack ALU attached to the operand bus.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hack ALU reference
    logic [15:0] ax1, ax2, ay1, ay2, ao1;
    always_comb begin
        ax1 = bus.zx ? 16'h0000 : bus.alu_x;
        ax2 = bus.nx ? ~ax1 : ax1;
        ay1 = bus.zy ? 16'h0000 : bus.alu_y;
        ay2 = bus.ny ? ~ay1 : ay1;
        ao1 = bus.f ? (ax2 + ay2) : (ax2 & ay2);
        bus.alu_out = bus.no ? ~ao1 : ao1;
        bus.alu_zr  = (bus.alu_out == 16'h0000);
        bus.alu_ng  = bus.alu_out[15];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [15:0] v);
        bus.instr       = v;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        bus.mem_in = 16'h0000;
        #12;
        checks++;
        if (bus.a_reg !== 16'h0 || bus.d_reg !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: a=%h d=%h required 0000 0000", bus.a_reg, bus.d_reg);
        end
        checks++;
        if ({bus.busy, bus.instr_ready, bus.mem_we, bus.jump} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctrl: busy/ready/we/jump=%b required 0100",
                     {bus.busy, bus.instr_ready, bus.mem_we, bus.jump});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_a_instr();
        offer(16'h0005);
        checks++;
        if (bus.a_reg !== 16'h0005 || bus.busy !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_instr: a=%h busy=%b ready=%b required 0005 0 1",
                     bus.a_reg, bus.busy, bus.instr_ready);
        end
        offer(16'h7fff);
        checks++;
        if (bus.a_reg !== 16'h7fff) begin
            errors++;
            $display("FAIL a_instr_max: a=%h required 7fff", bus.a_reg);
        end
        offer(16'h0005);
    endtask

    task automatic test_d_eq_a();
        offer(16'hec10);
        checks++;
        if ({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} !== 6'b110000 ||
            bus.alu_y !== 16'h0005 || bus.alu_x !== 16'h0000) begin
            errors++;
            $display("FAIL issue_ctrl: ctrl=%b x=%h y=%h required 110000 0000 0005",
                     {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, bus.alu_x, bus.alu_y);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.instr_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL issue_state: busy=%b ready=%b we=%b required 1 0 0",
                     bus.busy, bus.instr_ready, bus.mem_we);
        end
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.jump !== 1'b0 || bus.alu_y !== 16'h0 ||
            {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} !== 6'b0) begin
            errors++;
            $display("FAIL wb_quiet: we=%b jump=%b y=%h required 0 0 0000",
                     bus.mem_we, bus.jump, bus.alu_y);
        end
        step();
        checks++;
        if (bus.d_reg !== 16'h0005 || bus.a_reg !== 16'h0005 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL d_eq_a: d=%h a=%h busy=%b required 0005 0005 0",
                     bus.d_reg, bus.a_reg, bus.busy);
        end
    endtask

    task automatic test_mem_write();
        offer(16'h0010);
        offer(16'he308);
        step();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'h0005 ||
            bus.jump !== 1'b0) begin
            errors++;
            $display("FAIL mem_write: we=%b addr=%h wdata=%h jump=%b required 1 0010 0005 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.jump);
        end
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.a_reg !== 16'h0010 || bus.d_reg !== 16'h0005) begin
            errors++;
            $display("FAIL mem_write_after: we=%b a=%h d=%h required 0 0010 0005",
                     bus.mem_we, bus.a_reg, bus.d_reg);
        end
    endtask

    task automatic test_jump();
        offer(16'he301);
        step();
        checks++;
        if (bus.jump !== 1'b1 || bus.jump_addr !== 16'h0010 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL jgt_taken: jump=%b addr=%h we=%b required 1 0010 0",
                     bus.jump, bus.jump_addr, bus.mem_we);
        end
        step();
        checks++;
        if (bus.jump !== 1'b0) begin
            errors++;
            $display("FAIL jump_pulse: jump=%b required 0", bus.jump);
        end
        offer(16'hea90);
        step();
        step();
        checks++;
        if (bus.d_reg !== 16'h0000) begin
            errors++;
            $display("FAIL d_zero: d=%h required 0000", bus.d_reg);
        end
        offer(16'he301);
        step();
        checks++;
        if (bus.jump !== 1'b0) begin
            errors++;
            $display("FAIL jgt_not_taken: jump=%b required 0", bus.jump);
        end
        step();
        offer(16'hea87);
        step();
        checks++;
        if (bus.jump !== 1'b1 || bus.jump_addr !== 16'h0010) begin
            errors++;
            $display("FAIL jmp: jump=%b addr=%h required 1 0010", bus.jump, bus.jump_addr);
        end
        step();
    endtask

    // AM=D+1;JMP with bits 14:13 cleared: old A feeds address and target.
    task automatic test_dest_a_old_addr();
        offer(16'h87ef);
        step();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'h0001 ||
            bus.jump !== 1'b1 || bus.jump_addr !== 16'h0010) begin
            errors++;
            $display("FAIL dest_a_wb: we=%b addr=%h wdata=%h jump=%b tgt=%h required 1 0010 0001 1 0010",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.jump, bus.jump_addr);
        end
        step();
        checks++;
        if (bus.a_reg !== 16'h0001 || bus.d_reg !== 16'h0000) begin
            errors++;
            $display("FAIL dest_a_after: a=%h d=%h required 0001 0000", bus.a_reg, bus.d_reg);
        end
    endtask

    task automatic test_m_operand();
        bus.mem_in = 16'h1234;
        offer(16'hfc30);
        checks++;
        if (bus.alu_y !== 16'h1234) begin
            errors++;
            $display("FAIL m_operand: y=%h required 1234", bus.alu_y);
        end
        step();
        step();
        checks++;
        if (bus.a_reg !== 16'h1234 || bus.d_reg !== 16'h1234) begin
            errors++;
            $display("FAIL ad_dest: a=%h d=%h required 1234 1234", bus.a_reg, bus.d_reg);
        end
        bus.mem_in = 16'h0000;
    endtask

    task automatic test_back_to_back();
        bus.instr_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.instr = 16'(i);
            step();
            checks++;
            if (bus.a_reg !== 16'(i) || bus.instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_a%0d: a=%h ready=%b required %h 1",
                         i, bus.a_reg, bus.instr_ready, 16'(i));
            end
        end
        bus.instr = 16'hec10;
        step();
        bus.instr = 16'h0007;
        checks++;
        if (bus.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_issue_ready: ready=%b required 0", bus.instr_ready);
        end
        step();
        checks++;
        if (bus.a_reg !== 16'h0003 || bus.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wb_hold: a=%h ready=%b required 0003 0", bus.a_reg, bus.instr_ready);
        end
        step();
        checks++;
        if (bus.d_reg !== 16'h0003 || bus.a_reg !== 16'h0003 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: d=%h a=%h ready=%b required 0003 0003 1",
                     bus.d_reg, bus.a_reg, bus.instr_ready);
        end
        step();
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.a_reg !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_next: a=%h required 0007", bus.a_reg);
        end
    endtask

    task automatic test_reset_in_wb();
        offer(16'h0005);
        offer(16'hec10);
        step();
        step();
        offer(16'h0010);
        offer(16'he308);
        step();
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_wb_pre: we=%b required 1", bus.mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.d_reg !== 16'h0 || bus.a_reg !== 16'h0 ||
            bus.busy !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wb: we=%b d=%h a=%h busy=%b ready=%b required 0 0000 0000 0 1",
                     bus.mem_we, bus.d_reg, bus.a_reg, bus.busy, bus.instr_ready);
        end
        step();
        rst_n = 1'b1;
        offer(16'h0009);
        checks++;
        if (bus.a_reg !== 16'h0009 || bus.mem_we !== 1'b0 || bus.d_reg !== 16'h0) begin
            errors++;
            $display("FAIL post_rst_hs: a=%h we=%b d=%h required 0009 0 0000",
                     bus.a_reg, bus.mem_we, bus.d_reg);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a_instr();
        test_d_eq_a();
        test_mem_write();
        test_jump();
        test_dest_a_old_addr();
        test_m_operand();
        test_back_to_back();
        test_reset_in_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  instruction word offered.
REQ-005 instr_ready  output  1  stage accepts instruction this cycle.
REQ-006 instr  input  16  Hack instruction: bit15=0 A-instr; bit15=1 C-instr {111,a,c1..c6,d1,d2,d3,j1,j2,j3}.
REQ-007 mem_in  input  16  M operand, valid whenever state=ISSUE.
REQ-008 alu_x, alu_y  output  16 each  ALU operands.
REQ-009 zx, nx, zy, ny, f, no  output  1 each  ALU control bits.
REQ-010 alu_out  input  16; alu_zr, alu_ng  input  1 each  combinational ALU result and flags.
REQ-011 mem_we  output  1; mem_addr, mem_wdata  output  16  M write port.
REQ-012 jump  output  1; jump_addr  output  16  branch-taken pulse and target.
REQ-013 a_reg, d_reg  output  16  architectural A and D registers.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; instr_ready=1 only in IDLE.
REQ-016 IDLE, handshake (instr_valid & instr_ready), bit15=0: A <= {1'b0, instr[14:0]} next edge; stay IDLE (1-cycle throughput).
REQ-017 IDLE, handshake, bit15=1: latch instr into ir; go ISSUE.
REQ-018 ISSUE (exactly one cycle): {zx,nx,zy,ny,f,no} = ir[11:6]; alu_x = D; alu_y = ir[12] ? mem_in : A.
REQ-019 ISSUE, at end of cycle: capture alu_out, alu_zr, alu_ng into result registers; go WB.
REQ-020 Control outputs SHALL be 0 and alu_x/alu_y SHALL be 0 outside ISSUE.
REQ-021 WB (one cycle): mem_we = ir[3], mem_wdata = result, mem_addr = A value held before this WB.
REQ-022 WB, next edge: if ir[5], A <= result; if ir[4], D <= result; both may update together.
REQ-023 WB: jump = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr); jump_addr = pre-WB A.
REQ-024 mem_we and jump SHALL be single-cycle pulses, 0 outside WB.
REQ-025 C-instr latency: 3 cycles from handshake to A/D update visible; no new instruction accepted until back in IDLE.
REQ-026 instr_valid outside IDLE SHALL be ignored; instruction is not consumed.
REQ-027 dest A with jump or M write in same instruction: addr/target use old A; A updates after.
REQ-028 instr bits 14:13 of C-instr SHALL be ignored.
REQ-029 All arithmetic is performed externally; this block does no width extension beyond REQ-016.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, A=0, D=0, ir=0, result regs=0, all controls 0, mem_we=0, jump=0.
REQ-031 Reset during ISSUE or WB SHALL abort the instruction with no A/D/M write and no jump.
REQ-032 First handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 After reset, instr=0x0005 valid -> next cycle a_reg=0x0005, busy=0, instr_ready=1.
REQ-034 A=5, instr=0xEC10 (D=A) -> ISSUE shows zx..no=110000, alu_y=5; 3 cycles after handshake d_reg=5, mem_we never high.
REQ-035 D=5, A=0x0010, instr=0xE308 (M=D) -> WB cycle mem_we=1, mem_addr=0x0010, mem_wdata=5; A, D unchanged.
REQ-036 D=5, instr=0xE301 (D;JGT) -> jump=1 for one cycle, jump_addr=A; with D=0 -> jump=0; instr=0xEA87 (0;JMP) -> jump=1.
REQ-037 instr_valid held high through a C-instr -> second instr accepted only in IDLE after WB; back-to-back A-instrs accepted every cycle.
REQ-038 rst_n pulsed low during WB of 0xE308 -> mem_we=0 immediately, D=0, state IDLE.
